mixed_sign_mac: RTL and testbench
=================================

MIXED_SIGN_MAC -- requirements
Module: mixed_sign_mac

Interface
REQ-001 Parameter: SHIFT, default 4, arithmetic right shift applied to the accumulator before saturation (0..12).
REQ-002 Parameter: MAX_LEN, default 16, maximum beats per vector (1..16).
REQ-003 The clock port SHALL be clk, input, 1 bit; all state updates on its rising edge.
REQ-004 The reset port SHALL be rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 a SHALL be input, 8 bits, unsigned operand.
REQ-006 b SHALL be input, 8 bits, signed two's-complement operand.
REQ-007 in_valid SHALL be input, 1 bit; the a/b/in_last beat is valid.
REQ-008 in_last SHALL be input, 1 bit; marks the final beat of a vector.
REQ-009 in_ready SHALL be output, 1 bit; the block accepts a beat this cycle.
REQ-010 result SHALL be output, signed 8 bits; saturated dot-product result.
REQ-011 sat SHALL be output, 1 bit; result was clipped.
REQ-012 len_err SHALL be output, 1 bit; the vector was force-terminated at MAX_LEN.
REQ-013 out_valid SHALL be output, 1 bit; result/sat/len_err are valid.
REQ-014 out_ready SHALL be input, 1 bit; downstream accepts the result.

Function
REQ-015 A beat SHALL be accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-016 Product SHALL be computed as zero-extended a (9-bit signed, always non-negative) times sign-extended b, giving a 17-bit signed value; a SHALL never be sign-interpreted.
REQ-017 The accumulator SHALL be 21-bit signed; every accepted beat adds its sign-extended product, so the full range is reached without overflow.
REQ-018 The FSM SHALL have states IDLE, ACC and HOLD.
- IDLE: accumulator and count are 0.
- ACC: at least one beat accepted.
- HOLD: result is presented.
REQ-019 in_ready SHALL be 1 in IDLE and ACC, and 0 in HOLD.
REQ-020 State transitions on an accepted beat:
- IDLE to ACC when in_last=0.
- IDLE or ACC to HOLD when in_last=1, or when the beat count reaches MAX_LEN.
REQ-021 On entry to HOLD:
- result SHALL be the accumulator (including the final beat) arithmetically shifted right by SHIFT, then clamped to [-128, 127].
- sat SHALL be 1 if clamping occurred.
REQ-022 Latency: out_valid SHALL rise on the edge that accepts the final beat; it is visible the cycle after the final handshake.
REQ-023 Hold behaviour:
- result, sat, len_err and out_valid SHALL hold stable in HOLD until out_valid and out_ready are both 1.
- On that edge the FSM goes to IDLE, and the accumulator and count clear.
REQ-024 When MAX_LEN beats are accepted with in_last=0 on the last of them, the vector SHALL terminate, with len_err=1 in HOLD; a following in_last is treated as a new vector.
REQ-025 A vector whose final beat has in_last=1 exactly at beat MAX_LEN SHALL give len_err=0.
REQ-026 Single-beat vectors (IDLE with in_last=1) SHALL go directly to HOLD.
REQ-027 in_valid deasserted in ACC SHALL leave the accumulator and count unchanged (bubbles allowed).
REQ-028 Input beats presented during HOLD SHALL be ignored and not lost; they remain pending because in_ready=0.
REQ-029 The shift SHALL round toward negative infinity (plain arithmetic shift); no rounding constant is added.

Reset
REQ-030 While rst_n=0, asynchronously:
- state SHALL be IDLE;
- accumulator and count SHALL be 0;
- result SHALL be 0 and sat, len_err and out_valid SHALL be 0;
- in_ready SHALL be 0.
REQ-031 in_ready SHALL become 1 on the first clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-vector or in HOLD SHALL discard all partial and pending results with no output handshake.

Verification
REQ-033 SHIFT=4: beats (a=255,b=127),(a=255,b=127,last), out_ready=1 -> accumulator 64770, shifted 4048, result=127, sat=1, len_err=0, one cycle after the last beat.
REQ-034 SHIFT=4: single beat a=200, b=-1, last -> accumulator -200, shifted -13, result=-13, sat=0; verifies a is treated as unsigned (not -56).
REQ-035 MAX_LEN=16: 16 beats a=1, b=16, in_last=0 -> HOLD after the 16th beat, result=16, len_err=1; the next beat starts a fresh vector.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0 and result stable; raising out_ready gives one transfer, then IDLE accepts the pending beat.
REQ-037 Assert rst_n=0 after 3 beats of a vector -> all outputs 0 immediately; after release, a new 1-beat vector (a=16, b=2, SHIFT=4) gives result=2.

Source files
------------

// File: rtl/mixed_sign_mac.sv
// Streaming dot product of unsigned a by signed b. The sum is shifted, saturated to
// int8 and held until downstream accepts it. A vector ends on in_last or at MAX_LEN beats.
module mixed_sign_mac #(
  parameter int SHIFT   = 4,
  parameter int MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic signed [7:0] result,
  output logic              sat,
  output logic              len_err,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CW = 5;
  localparam int AW = 21;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t               state, state_nxt;
  logic                 rdy_en;
  logic signed [AW-1:0] acc;
  logic [CW-1:0]        cnt;

  logic signed [16:0]   prod;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shifted;
  logic [CW-1:0]        cnt_nxt;
  logic                 accept;
  logic                 done;
  logic                 clip_hi;
  logic                 clip_lo;
  logic signed [7:0]    clamped;

  // a is widened with a zero MSB so it can never be read as negative.
  assign prod    = $signed({1'b0, a}) * $signed(b);
  assign sum     = acc + {{(AW-17){prod[16]}}, prod};
  assign shifted = sum >>> SHIFT;
  assign cnt_nxt = cnt + 5'd1;

  // Readiness is held off until the first clock edge after reset is released.
  assign in_ready = rdy_en && (state != HOLD);
  assign accept   = in_valid && in_ready;
  assign done     = in_last || (cnt_nxt == CW'(MAX_LEN));

  assign clip_hi = shifted > $signed(21'sd127);
  assign clip_lo = shifted < $signed(-21'sd128);

  always_comb begin
    clamped = shifted[7:0];
    if (clip_hi)      clamped = 8'sd127;
    else if (clip_lo) clamped = -8'sd128;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC: if (accept) state_nxt = done ? HOLD : ACC;
      HOLD:      if (out_valid && out_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      sat       <= 1'b0;
      len_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (state == HOLD) begin
        if (out_valid && out_ready) begin
          acc       <= '0;
          cnt       <= '0;
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        acc <= sum;
        cnt <= cnt_nxt;
        if (done) begin
          result    <= clamped;
          sat       <= clip_hi || clip_lo;
          len_err   <= !in_last;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mixed_sign_mac.sv
// Directed bench for mixed_sign_mac: a plain-integer model is checked every cycle,
// and a few literal expectations pin both the model and the DUT.
module tb_mixed_sign_mac;
  localparam int SHIFT   = 4;
  localparam int MAX_LEN = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        a = '0;
  logic signed [7:0] b = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic signed [7:0] result;
  logic              sat;
  logic              len_err;
  logic              out_valid;
  logic              out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  mixed_sign_mac #(.SHIFT(SHIFT), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .result(result), .sat(sat), .len_err(len_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer accumulator, beat counter, a held result.
  int m_acc, m_cnt, m_res;
  bit m_started, m_hold, m_sat, m_lerr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; m_res = 0;
      m_started = 0; m_hold = 0; m_sat = 0; m_lerr = 0;
    end else begin
      bit was_started;
      was_started = m_started;
      m_started = 1;
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 0; m_acc = 0; m_cnt = 0;
        end
      end else if (was_started && in_valid) begin
        m_acc += int'(a) * int'(b);
        m_cnt++;
        if (in_last || m_cnt == MAX_LEN) begin
          int sh;
          sh = m_acc >>> SHIFT;
          m_sat = (sh > 127) || (sh < -128);
          m_res = (sh > 127) ? 127 : (sh < -128) ? -128 : sh;
          m_lerr = !in_last;
          m_hold = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(in_ready), int'(m_started && !m_hold));
      chk("out_valid", int'(out_valid), int'(m_hold));
      if (m_hold) begin
        chk("result", int'(result), m_res);
        chk("sat", int'(sat), int'(m_sat));
        chk("len_err", int'(len_err), int'(m_lerr));
      end
    end
  end

  task automatic beat(input int av, input int bv, input bit last);
    bit ok = 0;
    a = 8'(av); b = 8'(bv); in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic take(input int er, input int es, input int el);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    chk("result_seen", int'(ok), 1);
    chk("lit_result", int'(result), er);
    chk("lit_sat", int'(sat), es);
    chk("lit_len_err", int'(len_err), el);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_result", int'(result), 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_in_ready_pre", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("rel_in_ready_post", int'(in_ready), 1);

    // positive saturation, latency one cycle after final beat
    beat(255, 127, 0);
    beat(255, 127, 1);
    chk("lat_out_valid", int'(out_valid), 1);
    take(127, 1, 0);

    // a is unsigned: 200 * -1 = -200 -> -13
    beat(200, -1, 1);
    take(-13, 0, 0);

    // forced termination at MAX_LEN, then a fresh vector
    for (int i = 0; i < MAX_LEN; i++) beat(1, 16, 0);
    take(16, 0, 1);
    beat(16, 2, 1);
    take(2, 0, 0);

    // in_last exactly on beat MAX_LEN
    for (int i = 0; i < MAX_LEN; i++) beat(1, 16, i == MAX_LEN - 1);
    take(16, 0, 0);

    // backpressure with a pending beat
    beat(16, 2, 1);
    a = 8'd32; b = -8'sd4; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_result", int'(result), 2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    take(-8, 0, 0);

    // negative saturation
    beat(255, -128, 0);
    beat(255, -128, 1);
    take(-128, 1, 0);

    // bubbles inside a vector
    beat(10, 10, 0);
    repeat (3) @(posedge clk);
    #1;
    beat(10, 6, 1);
    take(10, 0, 0);

    // reset mid-vector
    beat(50, 50, 0);
    beat(50, 50, 0);
    beat(50, 50, 0);
    #3 rst_n = 1'b0; #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_sat", int'(sat), 0);
    chk("mid_rst_len_err", int'(len_err), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    beat(16, 2, 1);
    take(2, 0, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
